seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 24 ++
 rtl/seq_multiplier.sv | 107 ++++++++++
 2 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake/data bundle for the sequential shift-and-add multiplier.
// The master drives the operands and start request; the slave returns the product and status.
interface seq_multiplier_if #(
   parameter int WIDTH = 4
);
   logic                 ena;
   logic                 sgn;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [2*WIDTH-1:0]   Y;
   logic                 done;
   logic                 busy;
   logic [3:0]           state;

   modport master (
      output ena, sgn, A, B,
      input  Y, done, busy, state
   );

   modport slave (
      input  ena, sgn, A, B,
      output Y, done, busy, state
   );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, LSB first,
// with signed mode handled by multiplying magnitudes and negating the result.
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   seq_multiplier_if.slave   bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      FINISH  = 2'd2,
      RECOVER = 2'd3
   } stateT;

   stateT                stateQ, stateD;
   logic [2*WIDTH-1:0]   mcandQ, mcandD;
   logic [WIDTH-1:0]     multQ, multD;
   logic                 negQ, negD;
   logic [2*WIDTH-1:0]   accQ, accD;
   logic [CW-1:0]        cntQ, cntD;
   logic [2*WIDTH-1:0]   yQ, yD;
   logic                 doneQ, doneD;
   logic [WIDTH-1:0]     magA, magB;

   // Magnitudes in signed mode; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exact as unsigned.
   always_comb begin
      magA = (bus.sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      magB = (bus.sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= IDLE;
         mcandQ <= '0;
         multQ  <= '0;
         negQ   <= 1'b0;
         accQ   <= '0;
         cntQ   <= '0;
         yQ     <= '0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         mcandQ <= mcandD;
         multQ  <= multD;
         negQ   <= negD;
         accQ   <= accD;
         cntQ   <= cntD;
         yQ     <= yD;
         doneQ  <= doneD;
      end
   end

   // The multiplicand shifts left and the multiplier shifts right each COMPUTE cycle,
   // so bit 0 of multQ is always the current multiplier bit.
   always_comb begin
      stateD = stateQ;
      mcandD = mcandQ;
      multD  = multQ;
      negD   = negQ;
      accD   = accQ;
      cntD   = cntQ;
      yD     = yQ;
      doneD  = 1'b0;
      case (stateQ)
         IDLE: begin
            if (bus.ena) begin
               mcandD = {{WIDTH{1'b0}}, magA};
               multD  = magB;
               negD   = bus.sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               accD   = '0;
               cntD   = '0;
               stateD = COMPUTE;
            end
         end
         COMPUTE: begin
            if (multQ[0]) begin
               accD = accQ + mcandQ;
            end
            mcandD = mcandQ << 1;
            multD  = multQ >> 1;
            cntD   = cntQ + 1'b1;
            if (cntQ == CW'(WIDTH - 1)) begin
               stateD = FINISH;
               yD     = negQ ? -accD : accD;
               doneD  = 1'b1;
            end
         end
         FINISH: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   assign bus.Y     = yQ;
   assign bus.done  = doneQ;
   assign bus.busy  = (stateQ == COMPUTE) || (stateQ == FINISH);
   assign bus.state = {2'b00, stateQ};

endmodule
